// File: rtl/snapshot_assembler_pkg.sv
// Shared beamformer package for the snapshot assembler and its neighbours.
// Holds the sample width, the channel and beat counts, the assembler state
// encoding, and the helper that packs four {I,Q} channel samples onto one
// 144-bit bus. The helper puts the first channel in the most significant slice.
package snapshot_assembler_pkg;

    localparam int W           = 18;  // width of one I or Q component
    localparam int NCH         = 8;   // channels per snapshot
    localparam int FRAME_BEATS = 9;   // 8 channels plus the desired signal d
    localparam int CNT_W       = 4;   // beat counter width (values 0..8)

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RESYNC  = 2'd1,
        FULL    = 2'd2
    } state_t;

    // Packs channels (c0 first) as {c0I,c0Q,c1I,c1Q,c2I,c2Q,c3I,c3Q}.
    function automatic logic [8*W-1:0] pack_quad(
        input logic [2*W-1:0] c0,
        input logic [2*W-1:0] c1,
        input logic [2*W-1:0] c2,
        input logic [2*W-1:0] c3
    );
        return {c0, c1, c2, c3};
    endfunction

endpackage

// File: rtl/snapshot_assembler_sample_demux.sv
// Working-register bank for one frame being assembled.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   we        - write the incoming beat this cycle
//   sel       - beat index: 0..7 selects channel sel+1, 8 selects d
//   data      - {I,Q} sample
//   work_x    - channel working registers, index 0 holds channel 1
//   work_d    - desired-signal working register
module snapshot_assembler_sample_demux
    import snapshot_assembler_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [CNT_W-1:0]              sel,
    input  logic [2*W-1:0]                data,
    output logic [NCH-1:0][2*W-1:0]       work_x,
    output logic [2*W-1:0]                work_d
);

    logic [NCH-1:0][2*W-1:0] work_x_r;
    logic [2*W-1:0]          work_d_r;

    // Steer an accepted beat into the register selected by the beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_x_r <= '0;
            work_d_r <= '0;
        end else if (we) begin
            if (sel == 4'd8) begin
                work_d_r <= data;
            end else if (sel < 4'd8) begin
                work_x_r[sel[2:0]] <= data;
            end
        end
    end

    assign work_x = work_x_r;
    assign work_d = work_d_r;

endmodule

// File: rtl/snapshot_assembler.sv
// Assembles 8-channel snapshots (channels 1..8 then d, one {I,Q} beat per
// cycle) and presents them on xin14/xin58/din with a valid/ready handshake.
// Frames whose s_last marker is misplaced are dropped and counted.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   s_valid/s_ready      - input beat handshake, s_data = {I,Q}, s_last on beat 9
//   out_valid/out_ready  - snapshot handshake
//   xin14, xin58, din    - snapshot buses (channel 1 / 5 in the top slice)
//   frame_err            - one-cycle pulse per dropped frame
//   drop_cnt             - saturating dropped-frame count
module snapshot_assembler
    import snapshot_assembler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [2*W-1:0]   s_data,
    input  logic             s_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*W-1:0]   xin14,
    output logic [8*W-1:0]   xin58,
    output logic [2*W-1:0]   din,
    output logic             frame_err,
    output logic [15:0]      drop_cnt
);

    state_t                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic                    alive_r;       // low until the first edge after reset
    logic                    out_valid_r;
    logic [8*W-1:0]          xin14_r, xin58_r;
    logic [2*W-1:0]          din_r;
    logic                    frame_err_r;
    logic [15:0]             drop_cnt_r;

    logic                    slot_free_s, ready_s, accept_s;
    logic                    we_s, err_s, xfer_s;
    logic [CNT_W-1:0]        sel_s;
    logic [NCH-1:0][2*W-1:0] work_x_s;
    logic [2*W-1:0]          work_d_s;

    assign slot_free_s = !out_valid_r || out_ready;

    // Input readiness: always open while collecting or resyncing; in FULL only
    // when the output slot can take the completed frame this cycle.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            COLLECT: ready_s = alive_r;
            RESYNC:  ready_s = alive_r;
            FULL:    ready_s = alive_r && slot_free_s;
            default: ready_s = 1'b0;
        endcase
    end

    assign accept_s = s_valid && ready_s;

    // Next-state, beat steering, frame-error detection and transfer decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        we_s        = 1'b0;
        sel_s       = cnt_r;
        err_s       = 1'b0;
        xfer_s      = 1'b0;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (cnt_r == 4'd8) begin
                        if (s_last) begin
                            we_s        = 1'b1;
                            cnt_nxt_s   = 4'd0;
                            state_nxt_s = FULL;
                        end else begin
                            err_s       = 1'b1;
                            cnt_nxt_s   = 4'd0;
                            state_nxt_s = RESYNC;
                        end
                    end else begin
                        if (s_last) begin
                            // Early marker: discard the beat and restart the frame.
                            err_s     = 1'b1;
                            cnt_nxt_s = 4'd0;
                        end else begin
                            we_s      = 1'b1;
                            cnt_nxt_s = cnt_r + 4'd1;
                        end
                    end
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            RESYNC: begin
                if (accept_s && s_last) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = RESYNC;
                end
            end
            FULL: begin
                if (slot_free_s) begin
                    xfer_s      = 1'b1;
                    state_nxt_s = COLLECT;
                    sel_s       = 4'd0;
                    // A beat arriving with the transfer opens the next frame.
                    if (accept_s) begin
                        if (s_last) begin
                            err_s     = 1'b1;
                            cnt_nxt_s = 4'd0;
                        end else begin
                            we_s      = 1'b1;
                            cnt_nxt_s = 4'd1;
                        end
                    end else begin
                        cnt_nxt_s = 4'd0;
                    end
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = COLLECT;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    snapshot_assembler_sample_demux u_demux (
        .clk    (clk),
        .rst    (rst),
        .we     (we_s),
        .sel    (sel_s),
        .data   (s_data),
        .work_x (work_x_s),
        .work_d (work_d_s)
    );

    // Control state, output snapshot registers and the drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= COLLECT;
            cnt_r       <= 4'd0;
            alive_r     <= 1'b0;
            out_valid_r <= 1'b0;
            xin14_r     <= '0;
            xin58_r     <= '0;
            din_r       <= '0;
            frame_err_r <= 1'b0;
            drop_cnt_r  <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            alive_r     <= 1'b1;
            frame_err_r <= err_s;
            if (err_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                xin14_r     <= pack_quad(work_x_s[0], work_x_s[1], work_x_s[2], work_x_s[3]);
                xin58_r     <= pack_quad(work_x_s[4], work_x_s[5], work_x_s[6], work_x_s[7]);
                din_r       <= work_d_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign s_ready   = ready_s;
    assign out_valid = out_valid_r;
    assign xin14     = xin14_r;
    assign xin58     = xin58_r;
    assign din       = din_r;
    assign frame_err = frame_err_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_snapshot_assembler.sv
// Directed, scoreboard-based bench for snapshot_assembler.
module tb_snapshot_assembler;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [35:0]  s_data;
    logic         s_last;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] xin14;
    logic [143:0] xin58;
    logic [35:0]  din;
    logic         frame_err;
    logic [15:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int cyc    = 0;
    logic [323:0] exp_q[$];

    logic [323:0] prev_snap;
    bit           prev_stall = 1'b0;

    snapshot_assembler dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xin14     (xin14),
        .xin58     (xin58),
        .din       (din),
        .frame_err (frame_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [323:0] obs, input logic [323:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [35:0] mk(input int i);
        int q;
        q = -i;
        return {18'(i), 18'(q)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [35:0] d, input logic last);
        bit got;
        got     = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (s_ready === 1'b1) got = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        check("beat_accept", got, 1'b1);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Good frame: ch k gets I=base+k, Q=-(base+k); d gets base+100.
    task automatic send_frame(input int base);
        logic [323:0] e;
        e = '0;
        for (int k = 1; k <= 8; k++) e = {e[287:0], mk(base + k)};
        e = {e[287:0], mk(base + 100)};
        exp_q.push_back(e);
        for (int k = 1; k <= 8; k++) send_beat(mk(base + k), 1'b0);
        send_beat(mk(base + 100), 1'b1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
        check("drain", exp_q.size(), 0);
    endtask

    // Scoreboard pop on every delivered snapshot; stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_stable", {xin14, xin58, din}, prev_snap);
                check("hold_valid", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                check("snap_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("snap_data", {xin14, xin58, din}, exp_q.pop_front());
            end
            prev_stall <= out_valid && !out_ready;
            prev_snap  <= {xin14, xin58, din};
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1;
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_xin14", xin14, 0);
        check("rst_din", din, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1'b1);
        step();

        // Basic frame and latency.
        send_frame(0);
        idle();
        @(negedge clk);
        check("lat_not_yet", out_valid, 1'b0);
        @(negedge clk);
        check("lat_valid", out_valid, 1'b1);
        check("x1I", xin14[143:126], 18'd1);
        check("x1Q", xin14[125:108], 18'h3FFFF);
        check("x8Q", xin58[17:0], 18'h3FFF8);
        check("din", din, {18'd100, 18'h3FF9C});
        step();
        drain();

        // Back-to-back frames, no bubbles.
        stalls = 0;
        t0 = cyc;
        send_frame(1000);
        send_frame(2000);
        send_frame(3000);
        t1 = cyc;
        idle();
        check("b2b_stalls", stalls, 0);
        check("b2b_cycles", t1 - t0, 27);
        drain();

        // Backpressure over three frames.
        out_ready = 1'b0;
        fork
            begin
                send_frame(4000);
                send_frame(5000);
                send_frame(6000);
            end
            begin
                repeat (25) @(posedge clk);
                @(negedge clk);
                check("bp_s_ready", s_ready, 1'b0);
                check("bp_out_valid", out_valid, 1'b1);
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // s_last on beat 5.
        for (int k = 1; k <= 5; k++) send_beat(mk(k), k == 5);
        idle();
        @(negedge clk);
        check("early_frame_err", frame_err, 1'b1);
        check("early_drop_cnt", drop_cnt, 1);
        @(negedge clk);
        check("early_err_pulse_end", frame_err, 1'b0);
        step();
        send_frame(7000);
        idle();
        drain();

        // Missing s_last on beat 9, then resync on the 4th following beat.
        for (int k = 1; k <= 9; k++) send_beat(mk(k + 50), 1'b0);
        for (int k = 1; k <= 4; k++) send_beat(mk(k + 60), k == 4);
        idle();
        repeat (3) @(negedge clk);
        check("resync_drop_cnt", drop_cnt, 2);
        check("resync_no_valid", out_valid, 1'b0);
        step();
        send_frame(8000);
        idle();
        drain();

        // Reset in mid-frame.
        for (int k = 1; k <= 6; k++) send_beat(mk(k + 70), 1'b0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_xin14", xin14, 0);
        check("mid_rst_xin58", xin58, 0);
        check("mid_rst_din", din, 0);
        check("mid_rst_drop_cnt", drop_cnt, 0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_s_ready", s_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        send_frame(9000);
        idle();
        drain();
        check("final_drop_cnt", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
